// File: rtl/alu_pkg.sv
// Shared encodings for the ALU control path: ALUControl codes, ARM cmd/cond fields,
// NZCV bit positions and the issue controller's state type.
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_ORR = 4'b0011;
  localparam logic [3:0] ALU_EOR = 4'b0100;
  localparam logic [3:0] ALU_MVN = 4'b0101;
  localparam logic [3:0] ALU_ASR = 4'b0111;
  localparam logic [3:0] ALU_LSL = 4'b1000;
  localparam logic [3:0] ALU_LSR = 4'b1001;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_TST = 4'b1000;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;
  localparam logic [3:0] CMD_MVN = 4'b1111;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  typedef struct packed {
    logic [3:0] ctrl;
    logic       illegal;
    logic       arith;     // C and V come from the ALU only for add/subtract
    logic       cmp_like;  // flag-only ops: no register write, flags always set
  } dec_t;

  function automatic dec_t decode_cmd(input logic [3:0] cmd, input logic [1:0] sh);
    dec_t d;
    d = '{ctrl: ALU_ADD, illegal: 1'b0, arith: 1'b0, cmp_like: 1'b0};
    case (cmd)
      CMD_ADD: begin d.ctrl = ALU_ADD; d.arith = 1'b1; end
      CMD_SUB: begin d.ctrl = ALU_SUB; d.arith = 1'b1; end
      CMD_CMP: begin d.ctrl = ALU_SUB; d.arith = 1'b1; d.cmp_like = 1'b1; end
      CMD_AND: d.ctrl = ALU_AND;
      CMD_TST: begin d.ctrl = ALU_AND; d.cmp_like = 1'b1; end
      CMD_ORR: d.ctrl = ALU_ORR;
      CMD_EOR: d.ctrl = ALU_EOR;
      CMD_MVN: d.ctrl = ALU_MVN;
      CMD_MOV: begin
        case (sh)
          2'b00:   d.ctrl = ALU_LSL;
          2'b01:   d.ctrl = ALU_LSR;
          2'b10:   d.ctrl = ALU_ASR;
          default: d.illegal = 1'b1;
        endcase
      end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/cond_check.sv
// ARM condition-code evaluator: decides whether an instruction executes given NZCV.
module cond_check
  import alu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass,
  output logic       illegal
);

  logic w_n, w_z, w_c, w_v;

  assign w_n = flags[FLAG_N];
  assign w_z = flags[FLAG_Z];
  assign w_c = flags[FLAG_C];
  assign w_v = flags[FLAG_V];

  always_comb begin
    pass    = 1'b0;
    illegal = 1'b0;
    case (cond)
      COND_EQ: pass = w_z;
      COND_NE: pass = ~w_z;
      COND_CS: pass = w_c;
      COND_CC: pass = ~w_c;
      COND_MI: pass = w_n;
      COND_PL: pass = ~w_n;
      COND_VS: pass = w_v;
      COND_VC: pass = ~w_v;
      COND_HI: pass = w_c & ~w_z;
      COND_LS: pass = ~w_c | w_z;
      COND_GE: pass = (w_n == w_v);
      COND_LT: pass = (w_n != w_v);
      COND_GT: pass = ~w_z & (w_n == w_v);
      COND_LE: pass = w_z | (w_n != w_v);
      COND_AL: pass = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/condition controller: accepts one decoded instruction, drives ALUControl,
// evaluates its condition against the NZCV register and reports writes in DONE.
module alu_issue_ctrl
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_cond,
  input  logic [3:0] in_cmd,
  input  logic       in_s,
  input  logic [1:0] in_sh,
  output logic [3:0] alu_ctrl,
  input  logic [3:0] alu_flags,
  output logic [3:0] flags_q,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       reg_write,
  output logic       flag_write,
  output logic       cond_ex,
  output logic       illegal
);

  state_t     r_state, w_next;
  logic [3:0] r_cond, r_cmd, r_flags, w_flags_nxt;
  logic       r_s;
  logic [1:0] r_sh;
  logic       r_reg_write, r_flag_write, r_cond_ex, r_illegal;
  dec_t       w_dec;
  logic       w_pass, w_cond_ill, w_illegal, w_fe, w_rw;

  assign w_dec = decode_cmd(r_cmd, r_sh);

  cond_check u_cond_check (
    .cond    (r_cond),
    .flags   (r_flags),
    .pass    (w_pass),
    .illegal (w_cond_ill)
  );

  assign w_illegal = w_cond_ill | w_dec.illegal;
  assign w_fe      = w_pass & ~w_illegal & (r_s | w_dec.cmp_like);
  assign w_rw      = w_pass & ~w_illegal & ~w_dec.cmp_like;
  assign flags_q   = r_flags;

  always_comb begin
    w_flags_nxt = r_flags;
    if (w_fe) begin
      w_flags_nxt[FLAG_N] = alu_flags[FLAG_N];
      w_flags_nxt[FLAG_Z] = alu_flags[FLAG_Z];
      if (w_dec.arith) begin
        w_flags_nxt[FLAG_C] = alu_flags[FLAG_C];
        w_flags_nxt[FLAG_V] = alu_flags[FLAG_V];
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    alu_ctrl   = ALU_ADD;
    reg_write  = 1'b0;
    flag_write = 1'b0;
    cond_ex    = 1'b0;
    illegal    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = rst_n;
        if (in_valid) w_next = ST_EXEC;
      end
      ST_EXEC: begin
        alu_ctrl = w_dec.ctrl;
        cond_ex  = w_pass;
        illegal  = w_illegal;
        w_next   = ST_DONE;
      end
      ST_DONE: begin
        alu_ctrl   = w_dec.ctrl;
        out_valid  = 1'b1;
        reg_write  = r_reg_write;
        flag_write = r_flag_write;
        cond_ex    = r_cond_ex;
        illegal    = r_illegal;
        if (out_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Control state and architectural flags: cleared by reset, results latched at end of EXEC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_flags      <= 4'b0000;
      r_reg_write  <= 1'b0;
      r_flag_write <= 1'b0;
      r_cond_ex    <= 1'b0;
      r_illegal    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_EXEC) begin
        r_flags      <= w_flags_nxt;
        r_reg_write  <= w_rw;
        r_flag_write <= w_fe;
        r_cond_ex    <= w_pass;
        r_illegal    <= w_illegal;
      end
    end
  end

  // Instruction fields: captured only on accept, no reset needed
  always_ff @(posedge clk) begin
    if (r_state == ST_IDLE && in_valid) begin
      r_cond <= in_cond;
      r_cmd  <= in_cmd;
      r_s    <= in_s;
      r_sh   <= in_sh;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: expected results are queued at issue and
// compared when the controller reaches its result phase.
module tb_alu_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_cond = 4'h0;
  logic [3:0] in_cmd = 4'h0;
  logic       in_s = 1'b0;
  logic [1:0] in_sh = 2'b00;
  logic [3:0] alu_ctrl;
  logic [3:0] alu_flags = 4'h0;
  logic [3:0] flags_q;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       reg_write, flag_write, cond_ex, illegal;

  typedef struct packed {
    logic [3:0] ctrl;
    logic [3:0] flags;
    logic       rw;
    logic       fw;
    logic       cx;
    logic       il;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_cond    (in_cond),
    .in_cmd     (in_cmd),
    .in_s       (in_s),
    .in_sh      (in_sh),
    .alu_ctrl   (alu_ctrl),
    .alu_flags  (alu_flags),
    .flags_q    (flags_q),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .reg_write  (reg_write),
    .flag_write (flag_write),
    .cond_ex    (cond_ex),
    .illegal    (illegal)
  );

  function automatic exp_t mk(input logic [3:0] ctrl, input logic [3:0] flags,
                              input logic rw, input logic fw, input logic cx, input logic il);
    exp_t e;
    e.ctrl = ctrl; e.flags = flags; e.rw = rw; e.fw = fw; e.cx = cx; e.il = il;
    return e;
  endfunction

  // Issue one instruction, check EXEC, then pop and check the result phase.
  task automatic run_instr(input string nm, input logic [3:0] cond, input logic [3:0] cmd,
                           input logic s, input logic [1:0] sh, input logic [3:0] af,
                           input exp_t e, input int hold);
    exp_t got_e;
    int   n;
    logic [3:0] fl_before;
    q.push_back(e);
    @(negedge clk);
    fl_before = flags_q;
    in_cond = cond; in_cmd = cmd; in_s = s; in_sh = sh; alu_flags = af; in_valid = 1'b1;
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL %s in_ready idle: got %b want 1", nm, in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_cmd = 4'($urandom); in_cond = 4'($urandom); in_sh = 2'($urandom); in_s = 1'($urandom);
    n_vec++;
    if (alu_ctrl !== e.ctrl || in_ready !== 1'b0 || out_valid !== 1'b0 || flags_q !== fl_before) begin
      n_err++;
      $display("FAIL %s exec: ctrl=%b rdy=%b ov=%b fl=%b want ctrl=%b rdy=0 ov=0 fl=%b",
               nm, alu_ctrl, in_ready, out_valid, flags_q, e.ctrl, fl_before);
    end
    n = 0;
    while (out_valid !== 1'b1 && n < 8) begin @(posedge clk); #1; n++; end
    alu_flags = 4'($urandom);
    n_vec++;
    if (n != 1) begin
      n_err++;
      $display("FAIL %s latency: got %0d edges want 1", nm, n);
    end
    if (out_valid === 1'b1 && q.size() > 0) begin
      got_e = q.pop_front();
      n_vec++;
      if (alu_ctrl !== got_e.ctrl || flags_q !== got_e.flags || reg_write !== got_e.rw ||
          flag_write !== got_e.fw || cond_ex !== got_e.cx || illegal !== got_e.il) begin
        n_err++;
        $display("FAIL %s result: ctrl=%b fl=%b rw=%b fw=%b cx=%b il=%b want ctrl=%b fl=%b rw=%b fw=%b cx=%b il=%b",
                 nm, alu_ctrl, flags_q, reg_write, flag_write, cond_ex, illegal,
                 got_e.ctrl, got_e.flags, got_e.rw, got_e.fw, got_e.cx, got_e.il);
      end
      for (int i = 0; i < hold; i++) begin
        in_valid = 1'b1;
        @(posedge clk); #1;
        alu_flags = 4'($urandom);
        n_vec++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || alu_ctrl !== got_e.ctrl ||
            flags_q !== got_e.flags || reg_write !== got_e.rw || flag_write !== got_e.fw ||
            cond_ex !== got_e.cx || illegal !== got_e.il) begin
          n_err++;
          $display("FAIL %s hold%0d: ov=%b rdy=%b ctrl=%b fl=%b rw=%b fw=%b want ov=1 rdy=0 ctrl=%b fl=%b rw=%b fw=%b",
                   nm, i, out_valid, in_ready, alu_ctrl, flags_q, reg_write, flag_write,
                   got_e.ctrl, got_e.flags, got_e.rw, got_e.fw);
        end
      end
      in_valid = 1'b0;
    end else begin
      if (q.size() > 0) void'(q.pop_front());
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || alu_ctrl !== 4'b0000) begin
      n_err++;
      $display("FAIL %s release: ov=%b rdy=%b ctrl=%b want ov=0 rdy=1 ctrl=0000",
               nm, out_valid, in_ready, alu_ctrl);
    end
  endtask

  task automatic test_reset();
    #1;
    n_vec++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || flags_q !== 4'b0000 || alu_ctrl !== 4'b0000 ||
        reg_write !== 1'b0 || flag_write !== 1'b0 || cond_ex !== 1'b0 || illegal !== 1'b0) begin
      n_err++;
      $display("FAIL reset_hold: rdy=%b ov=%b fl=%b ctrl=%b rw=%b fw=%b cx=%b il=%b want all 0",
               in_ready, out_valid, flags_q, alu_ctrl, reg_write, flag_write, cond_ex, illegal);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: rdy=%b ov=%b want rdy=1 ov=0", in_ready, out_valid);
    end
  endtask

  task automatic test_add();
    run_instr("adds_al", 4'b1110, 4'b0100, 1'b1, 2'b00, 4'b0110, mk(4'b0000, 4'b0110, 1, 1, 1, 0), 0);
  endtask

  task automatic test_cmp_beq();
    run_instr("cmp", 4'b1110, 4'b1010, 1'b0, 2'b00, 4'b0100, mk(4'b0001, 4'b0100, 0, 1, 1, 0), 0);
    run_instr("sub_eq", 4'b0000, 4'b0010, 1'b0, 2'b00, 4'b1111, mk(4'b0001, 4'b0100, 1, 0, 1, 0), 0);
  endtask

  task automatic test_logic_keeps_cv();
    run_instr("adds_c", 4'b1110, 4'b0100, 1'b1, 2'b00, 4'b0010, mk(4'b0000, 4'b0010, 1, 1, 1, 0), 0);
    run_instr("ands", 4'b1110, 4'b0000, 1'b1, 2'b00, 4'b1001, mk(4'b0010, 4'b1010, 1, 1, 1, 0), 0);
  endtask

  task automatic test_cond_fail();
    run_instr("cmp_z", 4'b1110, 4'b1010, 1'b0, 2'b00, 4'b0100, mk(4'b0001, 4'b0100, 0, 1, 1, 0), 0);
    run_instr("adds_ne", 4'b0001, 4'b0100, 1'b1, 2'b00, 4'b1111, mk(4'b0000, 4'b0100, 0, 0, 0, 0), 0);
  endtask

  task automatic test_illegal();
    run_instr("bad_cmd", 4'b1110, 4'b0011, 1'b1, 2'b00, 4'b1111, mk(4'b0000, 4'b0100, 0, 0, 1, 1), 0);
    run_instr("bad_cond", 4'b1111, 4'b0100, 1'b1, 2'b00, 4'b1111, mk(4'b0000, 4'b0100, 0, 0, 0, 1), 0);
    run_instr("mov_sh11", 4'b1110, 4'b1101, 1'b1, 2'b11, 4'b1111, mk(4'b0000, 4'b0100, 0, 0, 1, 1), 0);
  endtask

  task automatic test_ops();
    run_instr("movs_asr", 4'b1110, 4'b1101, 1'b1, 2'b10, 4'b1000, mk(4'b0111, 4'b1000, 1, 1, 1, 0), 0);
    run_instr("mov_lsr", 4'b1110, 4'b1101, 1'b0, 2'b01, 4'b0111, mk(4'b1001, 4'b1000, 1, 0, 1, 0), 0);
    run_instr("tst_mi", 4'b0100, 4'b1000, 1'b0, 2'b00, 4'b0100, mk(4'b0010, 4'b0100, 0, 1, 1, 0), 0);
    run_instr("orrs_ge", 4'b1010, 4'b1100, 1'b1, 2'b00, 4'b1011, mk(4'b0011, 4'b1000, 1, 1, 1, 0), 0);
    run_instr("mvn_lt", 4'b1011, 4'b1111, 1'b0, 2'b00, 4'b0000, mk(4'b0101, 4'b1000, 1, 0, 1, 0), 0);
    run_instr("subs_hi", 4'b1000, 4'b0010, 1'b1, 2'b00, 4'b0000, mk(4'b0001, 4'b1000, 0, 0, 0, 0), 0);
  endtask

  task automatic test_backpressure();
    run_instr("eor_hold", 4'b1110, 4'b0001, 1'b0, 2'b00, 4'b0110, mk(4'b0100, 4'b1000, 1, 0, 1, 0), 5);
  endtask

  task automatic test_reset_mid_exec();
    @(negedge clk);
    in_cond = 4'b1110; in_cmd = 4'b0100; in_s = 1'b1; in_sh = 2'b00; alu_flags = 4'b1111;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (flags_q !== 4'b0000 || in_ready !== 1'b0 || alu_ctrl !== 4'b0000 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_exec: fl=%b rdy=%b ctrl=%b ov=%b want 0000/0/0000/0",
               flags_q, in_ready, alu_ctrl, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (flags_q !== 4'b0000 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_exec_release: fl=%b rdy=%b ov=%b want 0000/1/0", flags_q, in_ready, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    run_instr("b2b_adds", 4'b1110, 4'b0100, 1'b1, 2'b00, 4'b0011, mk(4'b0000, 4'b0011, 1, 1, 1, 0), 0);
    run_instr("b2b_vs", 4'b0110, 4'b1010, 1'b0, 2'b00, 4'b1010, mk(4'b0001, 4'b1010, 0, 1, 1, 0), 0);
  endtask

  initial begin
    test_reset();
    test_add();
    test_cmp_beq();
    test_logic_keeps_cv();
    test_cond_fail();
    test_illegal();
    test_ops();
    test_backpressure();
    test_reset_mid_exec();
    test_back_to_back();
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
